display_scan_sequencer: RTL and testbench

DISPLAY_SCAN_SEQUENCER -- requirements
Module: display_scan_sequencer

---
 rtl/display_scan_sequencer.sv | 132 +++++++++++++
 tb/tb_display_scan_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_sequencer.sv
// 2x2 window scanner over 8/16/32 channels; optional origin clamp via DISP_ORIGIN_CLAMP_EN.
// Latency: read issued in cycle t yields o_out_valid in cycle t+2; o_done rides the last output.
// No backpressure: one read per cycle while scanning; i_abort or reset discards in-flight reads.
module display_scan_sequencer (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [3:0]   i_origin_x,
   input  logic [3:0]   i_origin_y,
   input  logic [1:0]   i_depth,
   input  logic         i_abort,
   output logic         o_busy,
   output logic         o_rd_en,
   output logic [3:0]   o_rd_x,
   output logic [3:0]   o_rd_y,
   output logic         o_rd_bank,
   input  logic [127:0] i_rd_data,
   output logic         o_out_valid,
   output logic [13:0]  o_out_data,
   output logic         o_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0] state;
   logic [3:0] org_x;
   logic [3:0] org_y;
   logic [1:0] depth;
   // cnt = {channel[4:0], y_off, x_off}, so the scan order falls out of a plain increment
   logic [6:0] cnt;
   logic       drain_cnt;
   logic       rd_vld_d;
   logic       last_d;
   logic [3:0] lane_d;
   logic [4:0] ch_last;
   logic       scan;
   logic       last_rd;

   function automatic logic [3:0] clamp_origin(input logic [3:0] v);
`ifdef DISP_ORIGIN_CLAMP_EN
      if (v == 4'd0)
         return 4'd1;
      else if (v > 4'd7)
         return 4'd7;
      else
         return v;
`else
      return v;
`endif
   endfunction

   always_comb begin
      case (depth)
         2'd0:    ch_last = 5'd7;
         2'd1:    ch_last = 5'd15;
         default: ch_last = 5'd31;
      endcase
   end

   assign scan      = (state == ST_SCAN);
   assign last_rd   = (cnt == {ch_last, 2'b11});
   assign o_busy    = (state == ST_SCAN) || (state == ST_DRAIN);
   assign o_rd_en   = scan;
   assign o_rd_x    = scan ? 4'(org_x + {3'b000, cnt[0]}) : 4'd0;
   assign o_rd_y    = scan ? 4'(org_y + {3'b000, cnt[1]}) : 4'd0;
   assign o_rd_bank = scan ? cnt[6] : 1'b0;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         org_x       <= 4'd0;
         org_y       <= 4'd0;
         depth       <= 2'd0;
         cnt         <= 7'd0;
         drain_cnt   <= 1'b0;
         rd_vld_d    <= 1'b0;
         last_d      <= 1'b0;
         lane_d      <= 4'd0;
         o_out_valid <= 1'b0;
         o_out_data  <= 14'd0;
         o_done      <= 1'b0;
      end else if (i_abort && (state != ST_IDLE)) begin
         state       <= ST_IDLE;
         cnt         <= 7'd0;
         drain_cnt   <= 1'b0;
         rd_vld_d    <= 1'b0;
         last_d      <= 1'b0;
         lane_d      <= 4'd0;
         o_out_valid <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         rd_vld_d    <= scan;
         lane_d      <= scan ? cnt[5:2] : 4'd0;
         last_d      <= scan && last_rd;
         o_out_valid <= rd_vld_d;
         o_done      <= last_d;
         if (rd_vld_d)
            o_out_data <= {6'd0, i_rd_data[{lane_d, 3'b000} +: 8]};

         case (state)
            ST_IDLE: begin
               if (i_start && !i_abort) begin
                  org_x <= clamp_origin(i_origin_x);
                  org_y <= clamp_origin(i_origin_y);
                  depth <= i_depth;
                  cnt   <= 7'd0;
                  state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (last_rd) begin
                  cnt       <= 7'd0;
                  drain_cnt <= 1'b0;
                  state     <= ST_DRAIN;
               end else begin
                  cnt <= 7'(cnt + 7'd1);
               end
            end
            ST_DRAIN: begin
               if (drain_cnt)
                  state <= ST_IDLE;
               else
                  drain_cnt <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Bench for display_scan_sequencer: per-cycle expectation tables built from scan rules,
// a simple lane memory model, and literal spot checks on recorded DUT history.
module tb_display_scan_sequencer;

   localparam int N = 1024;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_start;
   logic [3:0]   i_origin_x;
   logic [3:0]   i_origin_y;
   logic [1:0]   i_depth;
   logic         i_abort;
   logic         o_busy;
   logic         o_rd_en;
   logic [3:0]   o_rd_x;
   logic [3:0]   o_rd_y;
   logic         o_rd_bank;
   logic [127:0] i_rd_data;
   logic         o_out_valid;
   logic [13:0]  o_out_data;
   logic         o_done;

   display_scan_sequencer dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_origin_x  (i_origin_x),
      .i_origin_y  (i_origin_y),
      .i_depth     (i_depth),
      .i_abort     (i_abort),
      .o_busy      (o_busy),
      .o_rd_en     (o_rd_en),
      .o_rd_x      (o_rd_x),
      .o_rd_y      (o_rd_y),
      .o_rd_bank   (o_rd_bank),
      .i_rd_data   (i_rd_data),
      .o_out_valid (o_out_valid),
      .o_out_data  (o_out_data),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic        exp_busy [N];
   logic        exp_en   [N];
   logic [3:0]  exp_x    [N];
   logic [3:0]  exp_y    [N];
   logic        exp_bank [N];
   logic        exp_vld  [N];
   logic [13:0] exp_dat  [N];
   logic        exp_done [N];

   logic        dut_busy [N];
   logic        dut_en   [N];
   logic [3:0]  dut_x    [N];
   logic [3:0]  dut_y    [N];
   logic        dut_bank [N];
   logic        dut_vld  [N];
   logic [13:0] dut_dat  [N];
   logic        dut_done [N];

   function automatic logic [7:0] mbyte(input int x, input int y, input int b, input int l);
      return 8'((x * 37 + y * 11 + b * 101 + l * 7) % 256);
   endfunction

   // Memory model: answers the read seen at an edge during the following cycle
   logic       m_en = 1'b0;
   logic [3:0] m_x = 4'd0;
   logic [3:0] m_y = 4'd0;
   logic       m_b = 1'b0;
   always @(posedge i_clk) begin
      m_en <= o_rd_en;
      m_x  <= o_rd_x;
      m_y  <= o_rd_y;
      m_b  <= o_rd_bank;
   end
   always_comb begin
      i_rd_data = {4{32'hA5C3_5A3C}};
      if (m_en)
         for (int l = 0; l < 16; l++)
            i_rd_data[l*8 +: 8] = mbyte(int'(m_x), int'(m_y), int'(m_b), l);
   end

   function automatic logic [3:0] clampv(input logic [3:0] v);
`ifdef DISP_ORIGIN_CLAMP_EN
      if (v == 4'd0) return 4'd1;
      if (v > 4'd7) return 4'd7;
      return v;
`else
      return v;
`endif
   endfunction

   task automatic sched(input int s, input logic [3:0] ox, input logic [3:0] oy, input logic [1:0] dsel);
      int d;
      d = (dsel == 2'd0) ? 8 : (dsel == 2'd1) ? 16 : 32;
      for (int t = s + 1; t <= s + 4 * d + 2; t++)
         if (t < N) exp_busy[t] = 1'b1;
      for (int k = 0; k < 4 * d; k++) begin
         int c, x, y, t;
         c = k / 4;
         x = int'(ox) + (k % 2);
         y = int'(oy) + ((k / 2) % 2);
         t = s + 1 + k;
         if (t + 2 < N) begin
            exp_en[t]    = 1'b1;
            exp_x[t]     = 4'(x);
            exp_y[t]     = 4'(y);
            exp_bank[t]  = (c >= 16);
            exp_vld[t+2] = 1'b1;
            exp_dat[t+2] = {6'd0, mbyte(x, y, c / 16, c % 16)};
         end
      end
      if (s + 4 * d + 2 < N) exp_done[s + 4 * d + 2] = 1'b1;
   endtask

   task automatic kill(input int n);
      for (int t = n; t < N; t++) begin
         exp_busy[t] = 1'b0; exp_en[t] = 1'b0; exp_x[t] = 4'd0; exp_y[t] = 4'd0;
         exp_bank[t] = 1'b0; exp_vld[t] = 1'b0; exp_dat[t] = 14'd0; exp_done[t] = 1'b0;
      end
   endtask

   task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, t, act, expv);
      end
   endtask

   always @(negedge i_clk) begin
      if (cyc < N) begin
         dut_busy[cyc] = o_busy;   dut_en[cyc]   = o_rd_en;
         dut_x[cyc]    = o_rd_x;   dut_y[cyc]    = o_rd_y;
         dut_bank[cyc] = o_rd_bank; dut_vld[cyc] = o_out_valid;
         dut_dat[cyc]  = o_out_data; dut_done[cyc] = o_done;
         if (chk_en) begin
            check("busy",  cyc, 32'(o_busy),      32'(exp_busy[cyc]));
            check("rd_en", cyc, 32'(o_rd_en),     32'(exp_en[cyc]));
            check("rd_x",  cyc, 32'(o_rd_x),      32'(exp_x[cyc]));
            check("rd_y",  cyc, 32'(o_rd_y),      32'(exp_y[cyc]));
            check("bank",  cyc, 32'(o_rd_bank),   32'(exp_bank[cyc]));
            check("valid", cyc, 32'(o_out_valid), 32'(exp_vld[cyc]));
            check("done",  cyc, 32'(o_done),      32'(exp_done[cyc]));
            if (exp_vld[cyc])
               check("data", cyc, 32'(o_out_data), 32'(exp_dat[cyc]));
         end
      end
   end

   task automatic drive(input logic st, input logic [3:0] ox, input logic [3:0] oy,
                        input logic [1:0] d, input logic ab, input logic rn);
      i_start = st; i_origin_x = ox; i_origin_y = oy; i_depth = d; i_abort = ab; i_rst_n = rn;
      if (cyc < N) begin
         if (!rn || ab)
            kill(cyc + 1);
         else if (st && !exp_busy[cyc])
            sched(cyc, clampv(ox), clampv(oy), d);
      end
      @(posedge i_clk);
      #1;
      cyc++;
      i_start = 1'b0; i_abort = 1'b0; i_rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1);
   endtask

   function automatic int vcount(input int a, input int b);
      int n = 0;
      for (int t = a; t <= b; t++) if (dut_vld[t] === 1'b1) n++;
      return n;
   endfunction

   function automatic int dcount(input int a, input int b);
      int n = 0;
      for (int t = a; t <= b; t++) if (dut_done[t] === 1'b1) n++;
      return n;
   endfunction

   int s;

   initial begin
      kill(0);
      i_start = 1'b0; i_origin_x = 4'd0; i_origin_y = 4'd0; i_depth = 2'd0; i_abort = 1'b0; i_rst_n = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
      chk_en = 1'b1;
      drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
      idle(2);
      check("rst_busy",  cyc - 1, 32'(dut_busy[cyc-1]), 32'd0);
      check("rst_valid", cyc - 1, 32'(dut_vld[cyc-1]),  32'd0);
      check("rst_data",  cyc - 1, 32'(dut_dat[cyc-1]),  32'd0);

      // Depth 8 at (1,1)
      s = cyc;
      drive(1'b1, 4'd1, 4'd1, 2'd0, 1'b0, 1'b1);
      idle(40);
      check("t1_count", s, vcount(s, s + 40), 32);
      check("t1_first_vld_cyc", s + 2, 32'(dut_vld[s+2]), 32'd0);
      check("t1_first_data", s + 3, 32'(dut_dat[s+3]), 32'd48);
      check("t1_done_at", s + 34, 32'(dut_done[s+34]), 32'd1);
      check("t1_done_cnt", s, dcount(s, s + 40), 1);

      // Depth 32 at (7,7): bank switch at channel 16, last read at (8,8)
      s = cyc;
      drive(1'b1, 4'd7, 4'd7, 2'd2, 1'b0, 1'b1);
      idle(136);
      check("t2_bank_ch15", s + 64, 32'(dut_bank[s+64]), 32'd0);
      check("t2_bank_ch16", s + 65, 32'(dut_bank[s+65]), 32'd1);
      check("t2_data_ch16", s + 67, 32'(dut_dat[s+67]), 32'd181);
      check("t2_last_x", s + 128, 32'(dut_x[s+128]), 32'd8);
      check("t2_last_y", s + 128, 32'(dut_y[s+128]), 32'd8);
      check("t2_last_data", s + 130, 32'(dut_dat[s+130]), 32'd78);
      check("t2_done_at", s + 130, 32'(dut_done[s+130]), 32'd1);
      check("t2_count", s, vcount(s, s + 136), 128);

      // Depth 16 with ignored restarts, then a start right at the first free cycle
      s = cyc;
      for (int i = 0; i < 110; i++)
         drive(i == 0 || i == 5 || i == 20 || i == 67,
               (i == 0) ? 4'd3 : 4'd9, (i == 0) ? 4'd2 : 4'd6,
               (i == 67) ? 2'd0 : ((i == 0) ? 2'd1 : 2'd2), 1'b0, 1'b1);
      check("t3_count", s, vcount(s, s + 66), 64);
      check("t3_done_at", s + 66, 32'(dut_done[s+66]), 32'd1);
      check("t3_idle_gap", s + 67, 32'(dut_busy[s+67]), 32'd0);
      check("t3_restart", s + 68, 32'(dut_busy[s+68]), 32'd1);

      // Abort in cycle 10
      s = cyc;
      for (int i = 0; i < 40; i++)
         drive(i == 0, 4'd2, 4'd5, 2'd0, i == 10, 1'b1);
      check("t4_busy_after", s + 11, 32'(dut_busy[s+11]), 32'd0);
      check("t4_vld_before", s, vcount(s, s + 10), 8);
      check("t4_vld_after", s + 11, vcount(s + 11, s + 39), 0);
      check("t4_no_done", s, dcount(s, s + 39), 0);

      // Out-of-range origin
      s = cyc;
      drive(1'b1, 4'd0, 4'd9, 2'd0, 1'b0, 1'b1);
      idle(36);
`ifdef DISP_ORIGIN_CLAMP_EN
      check("t5_x0", s + 1, 32'(dut_x[s+1]), 32'd1);
      check("t5_y0", s + 1, 32'(dut_y[s+1]), 32'd7);
      check("t5_x1", s + 4, 32'(dut_x[s+4]), 32'd2);
      check("t5_y1", s + 4, 32'(dut_y[s+4]), 32'd8);
`else
      check("t5_x0", s + 1, 32'(dut_x[s+1]), 32'd0);
      check("t5_y0", s + 1, 32'(dut_y[s+1]), 32'd9);
      check("t5_x1", s + 4, 32'(dut_x[s+4]), 32'd1);
      check("t5_y1", s + 4, 32'(dut_y[s+4]), 32'd10);
`endif

      // Reset in cycle 6 of a scan
      s = cyc;
      for (int i = 0; i < 40; i++)
         drive(i == 0, 4'd4, 4'd4, 2'd1, 1'b0, i != 6);
      check("t6_busy", s + 7, 32'(dut_busy[s+7]), 32'd0);
      check("t6_rd_en", s + 7, 32'(dut_en[s+7]), 32'd0);
      check("t6_data", s + 7, 32'(dut_dat[s+7]), 32'd0);
      check("t6_vld_after", s + 7, vcount(s + 7, s + 39), 0);

      // Abort and start together in IDLE
      s = cyc;
      drive(1'b1, 4'd1, 4'd1, 2'd0, 1'b1, 1'b1);
      idle(5);
      check("t7_busy", s + 1, 32'(dut_busy[s+1]), 32'd0);
      check("t7_rd_en", s + 1, 32'(dut_en[s+1]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
